// File: rtl/isocm_bram_arbiter_pkg.sv
// isocm_bram_arbiter_pkg: shared FSM state encoding plus lane width and word size constants
package isocm_bram_arbiter_pkg;
  typedef enum logic {CLEAR, RUN} state_e;
  localparam int LANE_W = 32;
  localparam int WORD_BYTES = 8;
endpackage

// File: rtl/isocm_bram_arbiter_if.sv
// isocm_bram_arbiter_if: one requester port (Req/WEN/Addr/WrData in, Gnt/RdValid/RdData/Err out), big-endian bit order
interface isocm_bram_arbiter_if #(parameter int DW = 64, parameter int AW = 32, parameter int NW = 2) ();
  logic Req;
  logic [0:NW-1] WEN;
  logic [0:AW-1] Addr;
  logic [0:DW-1] WrData;
  logic Gnt;
  logic RdValid;
  logic [0:DW-1] RdData;
  logic Err;
  modport master (output Req, WEN, Addr, WrData, input Gnt, RdValid, RdData, Err);
  modport slave (input Req, WEN, Addr, WrData, output Gnt, RdValid, RdData, Err);
endinterface

// File: rtl/isocm_rr_arb2.sv
// isocm_rr_arb2: two-way round-robin arbiter (clk, rst, req[1:0] in, gnt[1:0] out); ptr_q=1 favours requester 1
module isocm_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt[0] = req[0] & (~req[1] | ~ptr_q);
    gnt[1] = req[1] & (~req[0] | ptr_q);
    ptr_d = gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= rst ? 1'b0 : ptr_d;
endmodule

// File: rtl/isocm_bram_arbiter.sv
// isocm_bram_arbiter: two requester ports (M0/M1) arbitrated onto one BRAM port (BRAM_EN/WEN/Addr/Dout out, BRAM_Din in), optional zero-fill with Busy
module isocm_bram_arbiter
  import isocm_bram_arbiter_pkg::*;
#(
  parameter int C_MEMSIZE     = 'h4000,
  parameter int C_PORT_DWIDTH = 64,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_NUM_WE      = 2,
  parameter int C_INIT_CLEAR  = 1
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst,
  isocm_bram_arbiter_if.slave      M0,
  isocm_bram_arbiter_if.slave      M1,
  output logic                     Busy,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);
  localparam int AW = C_PORT_AWIDTH;
  state_e state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d, addr_q, addr_d, sel_addr;
  logic [0:C_NUM_WE-1] wen_q, wen_d, sel_wen;
  logic [0:C_PORT_DWIDTH-1] dout_q, dout_d, sel_data;
  logic en_q, en_d, rd1_q, rd1_d, err1_q, err1_d, src1_q, src1_d;
  logic rd2_q, rd2_d, err2_q, err2_d, src2_q, src2_d;
  logic [1:0] req, gnt;
  logic oor, hit, v0, v1;
  assign req = (BRAM_Rst || state_q != RUN) ? 2'b00 : {M1.Req, M0.Req};
  isocm_rr_arb2 u_arb (.clk(BRAM_Clk), .rst(BRAM_Rst), .req(req), .gnt(gnt));
  always_comb begin
    sel_wen = gnt[1] ? M1.WEN : M0.WEN;
    sel_addr = gnt[1] ? M1.Addr : M0.Addr;
    sel_data = gnt[1] ? M1.WrData : M0.WrData;
    oor = sel_addr >= AW'(C_MEMSIZE);
    hit = |gnt & ~oor;
    en_d = hit;
    wen_d = hit ? sel_wen : '0;
    addr_d = hit ? sel_addr & ~AW'(WORD_BYTES - 1) : '0;
    dout_d = hit ? sel_data : '0;
    // out-of-range reads still produce a (zero) response so ordering stays fixed-latency
    rd1_d = |gnt & ~|sel_wen;
    err1_d = |gnt & oor;
    src1_d = gnt[1];
    rd2_d = rd1_q;
    err2_d = err1_q;
    src2_d = src1_q;
    state_d = (state_q == CLEAR && clr_addr_q == AW'(C_MEMSIZE - WORD_BYTES)) ? RUN : state_q;
    clr_addr_d = state_q == CLEAR ? clr_addr_q + AW'(WORD_BYTES) : clr_addr_q;
  end
  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      state_q <= (C_INIT_CLEAR != 0) ? CLEAR : RUN;
      clr_addr_q <= '0;
      en_q <= 1'b0;
      wen_q <= '0;
      addr_q <= '0;
      dout_q <= '0;
      rd1_q <= 1'b0;
      err1_q <= 1'b0;
      src1_q <= 1'b0;
      rd2_q <= 1'b0;
      err2_q <= 1'b0;
      src2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_addr_q <= clr_addr_d;
      en_q <= en_d;
      wen_q <= wen_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      rd1_q <= rd1_d;
      err1_q <= err1_d;
      src1_q <= src1_d;
      rd2_q <= rd2_d;
      err2_q <= err2_d;
      src2_q <= src2_d;
    end
  end
  // the clear sweep drives the BRAM port directly from its counter so word k lands in cycle k
  assign Busy = BRAM_Rst ? (C_INIT_CLEAR != 0) : state_q == CLEAR;
  assign BRAM_EN = BRAM_Rst ? 1'b0 : state_q == CLEAR ? 1'b1 : en_q;
  assign BRAM_WEN = BRAM_Rst ? '0 : state_q == CLEAR ? '1 : wen_q;
  assign BRAM_Addr = BRAM_Rst ? '0 : state_q == CLEAR ? clr_addr_q : addr_q;
  assign BRAM_Dout = (BRAM_Rst || state_q == CLEAR) ? '0 : dout_q;
  assign v0 = ~BRAM_Rst & rd2_q & ~src2_q;
  assign v1 = ~BRAM_Rst & rd2_q & src2_q;
  assign M0.Gnt = gnt[0];
  assign M1.Gnt = gnt[1];
  assign M0.RdValid = v0;
  assign M1.RdValid = v1;
  assign M0.RdData = (v0 & ~err2_q) ? BRAM_Din : '0;
  assign M1.RdData = (v1 & ~err2_q) ? BRAM_Din : '0;
  assign M0.Err = ~BRAM_Rst & err2_q & ~src2_q;
  assign M1.Err = ~BRAM_Rst & err2_q & src2_q;
endmodule

// File: tb/tb_isocm_bram_arbiter.sv
// tb_isocm_bram_arbiter: directed scenario tests of isocm_bram_arbiter against a behavioural BRAM
module tb_isocm_bram_arbiter;
  import isocm_bram_arbiter_pkg::*;
  localparam logic [0:63] D1 = 64'h0123456789ABCDEF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, en;
  logic [0:1] wen;
  logic [0:31] addr;
  logic [0:63] dout, din;
  logic [10:0] idx;
  logic [0:63] mem [0:2047];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  isocm_bram_arbiter_if #(.DW(64), .AW(32), .NW(2)) m0 ();
  isocm_bram_arbiter_if #(.DW(64), .AW(32), .NW(2)) m1 ();
  isocm_bram_arbiter dut (
    .BRAM_Clk(clk), .BRAM_Rst(rst), .M0(m0), .M1(m1), .Busy(busy),
    .BRAM_EN(en), .BRAM_WEN(wen), .BRAM_Addr(addr), .BRAM_Dout(dout), .BRAM_Din(din)
  );
  assign idx = addr[18:28];
  always @(posedge clk) begin
    if (en) begin
      din <= mem[idx];
      for (int l = 0; l < 2; l++) if (wen[l]) mem[idx][l*LANE_W +: LANE_W] = dout[l*LANE_W +: LANE_W];
    end
  end
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input bit m, input logic r, input logic [0:1] w, input logic [0:31] a, input logic [0:63] d);
    if (m) begin
      m1.Req = r; m1.WEN = w; m1.Addr = a; m1.WrData = d;
    end else begin
      m0.Req = r; m0.WEN = w; m0.Addr = a; m0.WrData = d;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    drv(0, 0, 2'b00, 0, 0);
    drv(1, 1, 2'b00, 32'h8, 0);
    repeat (3) nxt();
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b want 1", busy); end
    total++; if ({en, wen, addr, dout} !== 99'h0) begin bad++; $display("FAIL rst_bram: got %b %b %h %h want zeros", en, wen, addr, dout); end
    total++; if ({m0.Gnt, m0.RdValid, m0.Err, m1.Gnt, m1.RdValid, m1.Err} !== 6'b0) begin bad++; $display("FAIL rst_ctl: got %b want 000000", {m0.Gnt, m0.RdValid, m0.Err, m1.Gnt, m1.RdValid, m1.Err}); end
    total++; if ({m0.RdData, m1.RdData} !== 128'h0) begin bad++; $display("FAIL rst_rddata: got %h %h want 0", m0.RdData, m1.RdData); end
  endtask
  task automatic test_clear;
    int nz;
    nxt();
    rst = 1'b0;
    drv(1, 0, 2'b00, 0, 0);
    drv(0, 1, 2'b00, 32'h20, 0);
    for (int k = 0; k < 2048; k++) begin
      @(negedge clk);
      total++;
      if ({busy, en, wen, addr, dout, m0.Gnt} !== {1'b1, 1'b1, 2'b11, 32'(k * 8), 64'h0, 1'b0}) begin
        bad++; $display("FAIL clear_word%0d: got busy=%b en=%b wen=%b addr=%h dout=%h gnt=%b want 1 1 11 %h 0 0", k, busy, en, wen, addr, dout, m0.Gnt, 32'(k * 8));
      end
      nxt();
    end
    @(negedge clk);
    total++; if ({busy, m0.Gnt, m1.Gnt} !== 3'b010) begin bad++; $display("FAIL run_first_gnt: got busy/g0/g1=%b want 010", {busy, m0.Gnt, m1.Gnt}); end
    nxt();
    drv(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    total++; if ({en, wen, addr, m0.Gnt} !== {1'b1, 2'b00, 32'h20, 1'b0}) begin bad++; $display("FAIL run_rd_cmd: got en=%b wen=%b addr=%h gnt=%b want 1 00 20 0", en, wen, addr, m0.Gnt); end
    nxt();
    @(negedge clk);
    total++; if ({m0.RdValid, m0.Err, m0.RdData} !== {1'b1, 1'b0, 64'h0}) begin bad++; $display("FAIL run_rd_resp: got v=%b e=%b d=%h want 1 0 0", m0.RdValid, m0.Err, m0.RdData); end
    nz = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== 64'h0) nz++;
    total++; if (nz !== 0) begin bad++; $display("FAIL clear_mem: got %0d nonzero words want 0", nz); end
  endtask
  task automatic test_write_read;
    nxt();
    drv(0, 1, 2'b11, 32'h10, D1);
    @(negedge clk);
    total++; if ({m0.Gnt, m1.Gnt} !== 2'b10) begin bad++; $display("FAIL wr_gnt: got %b want 10", {m0.Gnt, m1.Gnt}); end
    nxt();
    drv(0, 0, 2'b00, 0, 0);
    drv(1, 1, 2'b00, 32'h10, 0);
    @(negedge clk);
    total++; if ({m0.Gnt, m1.Gnt} !== 2'b01) begin bad++; $display("FAIL rd_gnt: got %b want 01", {m0.Gnt, m1.Gnt}); end
    total++; if ({en, wen, addr, dout} !== {1'b1, 2'b11, 32'h10, D1}) begin bad++; $display("FAIL wr_cmd: got en=%b wen=%b addr=%h dout=%h want 1 11 10 %h", en, wen, addr, dout, D1); end
    nxt();
    drv(1, 0, 2'b00, 0, 0);
    @(negedge clk);
    total++; if ({en, wen, addr, m1.RdValid} !== {1'b1, 2'b00, 32'h10, 1'b0}) begin bad++; $display("FAIL rd_cmd: got en=%b wen=%b addr=%h v=%b want 1 00 10 0", en, wen, addr, m1.RdValid); end
    nxt();
    @(negedge clk);
    total++; if ({m1.RdValid, m1.RdData, m0.RdValid} !== {1'b1, D1, 1'b0}) begin bad++; $display("FAIL rd_resp: got v1=%b d=%h v0=%b want 1 %h 0", m1.RdValid, m1.RdData, m0.RdValid, D1); end
    nxt();
    @(negedge clk);
    total++; if ({m1.RdValid, m1.RdData, en, wen} !== {1'b0, 64'h0, 1'b0, 2'b00}) begin bad++; $display("FAIL rd_after: got v=%b d=%h en=%b wen=%b want 0 0 0 00", m1.RdValid, m1.RdData, en, wen); end
  endtask
  task automatic test_back_to_back;
    logic [1:0] eg;
    for (int i = 0; i < 8; i++) begin
      nxt();
      if (i == 0) begin
        drv(0, 1, 2'b00, 32'h10, 0);
        drv(1, 1, 2'b00, 32'h20, 0);
      end
      if (i == 6) begin
        drv(0, 0, 2'b00, 0, 0);
        drv(1, 0, 2'b00, 0, 0);
      end
      @(negedge clk);
      eg = (i >= 6) ? 2'b00 : (i % 2 == 0) ? 2'b10 : 2'b01;
      total++; if ({m0.Gnt, m1.Gnt} !== eg) begin bad++; $display("FAIL rr_gnt%0d: got %b want %b", i, {m0.Gnt, m1.Gnt}, eg); end
      if (i >= 2) begin
        total++;
        if ({m0.RdValid, m0.RdData, m1.RdValid, m1.RdData} !== {i % 2 == 0, (i % 2 == 0) ? D1 : 64'h0, i % 2 == 1, 64'h0}) begin
          bad++; $display("FAIL rr_resp%0d: got v0=%b d0=%h v1=%b d1=%h", i, m0.RdValid, m0.RdData, m1.RdValid, m1.RdData);
        end
      end
    end
  endtask
  task automatic test_lanes;
    nxt();
    drv(0, 1, 2'b11, 32'h0, 64'hFFFFFFFF_FFFFFFFF);
    @(negedge clk);
    total++; if (m0.Gnt !== 1'b1) begin bad++; $display("FAIL ln_gnt0: got %b want 1", m0.Gnt); end
    nxt();
    drv(0, 1, 2'b10, 32'h0, 64'h0);
    @(negedge clk);
    total++; if ({m0.Gnt, en, wen, dout} !== {1'b1, 1'b1, 2'b11, 64'hFFFFFFFF_FFFFFFFF}) begin bad++; $display("FAIL ln_wr1: got g=%b en=%b wen=%b dout=%h", m0.Gnt, en, wen, dout); end
    nxt();
    drv(0, 1, 2'b00, 32'h5, 64'h0);
    @(negedge clk);
    total++; if ({m0.Gnt, en, wen, addr} !== {1'b1, 1'b1, 2'b10, 32'h0}) begin bad++; $display("FAIL ln_wr2: got g=%b en=%b wen=%b addr=%h want 1 1 10 0", m0.Gnt, en, wen, addr); end
    nxt();
    drv(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    total++; if ({en, wen, addr} !== {1'b1, 2'b00, 32'h0}) begin bad++; $display("FAIL ln_rdaddr: got en=%b wen=%b addr=%h want 1 00 0", en, wen, addr); end
    nxt();
    @(negedge clk);
    total++; if ({m0.RdValid, m0.RdData} !== {1'b1, 64'h00000000_FFFFFFFF}) begin bad++; $display("FAIL ln_data: got v=%b d=%h want 1 00000000ffffffff", m0.RdValid, m0.RdData); end
  endtask
  task automatic test_out_of_range;
    nxt();
    drv(1, 1, 2'b00, 32'h3FFF, 0);
    @(negedge clk);
    total++; if (m1.Gnt !== 1'b1) begin bad++; $display("FAIL or_gnt_edge: got %b want 1", m1.Gnt); end
    nxt();
    drv(1, 1, 2'b00, 32'h4000, 0);
    @(negedge clk);
    total++; if ({m1.Gnt, en, addr} !== {1'b1, 1'b1, 32'h3FF8}) begin bad++; $display("FAIL or_edge_cmd: got g=%b en=%b addr=%h want 1 1 3ff8", m1.Gnt, en, addr); end
    nxt();
    drv(1, 0, 2'b00, 0, 0);
    drv(0, 1, 2'b11, 32'h4008, 64'hAA);
    @(negedge clk);
    total++; if ({m0.Gnt, en, m1.RdValid, m1.Err, m1.RdData} !== {1'b1, 1'b0, 1'b1, 1'b0, 64'h0}) begin bad++; $display("FAIL or_edge_resp: got g0=%b en=%b v1=%b e1=%b d1=%h want 1 0 1 0 0", m0.Gnt, en, m1.RdValid, m1.Err, m1.RdData); end
    nxt();
    drv(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    total++; if ({en, m1.Err, m1.RdValid, m1.RdData, m0.Err} !== {1'b0, 1'b1, 1'b1, 64'h0, 1'b0}) begin bad++; $display("FAIL or_rd_err: got en=%b e1=%b v1=%b d1=%h e0=%b want 0 1 1 0 0", en, m1.Err, m1.RdValid, m1.RdData, m0.Err); end
    nxt();
    @(negedge clk);
    total++; if ({m0.Err, m0.RdValid, m1.Err, m1.RdValid, en} !== 5'b10000) begin bad++; $display("FAIL or_wr_err: got e0/v0/e1/v1/en=%b want 10000", {m0.Err, m0.RdValid, m1.Err, m1.RdValid, en}); end
    nxt();
    @(negedge clk);
    total++; if (m0.Err !== 1'b0) begin bad++; $display("FAIL or_err_pulse: got %b want 0", m0.Err); end
  endtask
  task automatic test_reset_mid;
    int n;
    nxt();
    drv(0, 1, 2'b00, 32'h10, 0);
    @(negedge clk);
    total++; if (m0.Gnt !== 1'b1) begin bad++; $display("FAIL rm_gnt: got %b want 1", m0.Gnt); end
    nxt();
    rst = 1'b1;
    drv(0, 0, 2'b00, 0, 0);
    @(negedge clk);
    total++; if ({busy, en, m0.RdValid} !== 3'b100) begin bad++; $display("FAIL rm_inrst: got busy/en/v0=%b want 100", {busy, en, m0.RdValid}); end
    nxt();
    rst = 1'b0;
    drv(0, 1, 2'b00, 32'h10, 0);
    drv(1, 1, 2'b00, 32'h20, 0);
    @(negedge clk);
    total++; if ({m0.RdValid, m0.Err, busy, en, wen, addr} !== {1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 32'h0}) begin bad++; $display("FAIL rm_restart: got v0=%b e0=%b busy=%b en=%b wen=%b addr=%h want 0 0 1 1 11 0", m0.RdValid, m0.Err, busy, en, wen, addr); end
    n = 1;
    for (int c = 0; c < 2100; c++) begin
      nxt();
      @(negedge clk);
      if (c == 0) begin
        total++; if ({m0.RdValid, addr} !== {1'b0, 32'h8}) begin bad++; $display("FAIL rm_word1: got v0=%b addr=%h want 0 8", m0.RdValid, addr); end
      end
      if (busy !== 1'b1) break;
      n++;
    end
    total++; if (n !== 2048) begin bad++; $display("FAIL rm_busy_len: got %0d cycles want 2048", n); end
    total++; if ({m0.Gnt, m1.Gnt} !== 2'b10) begin bad++; $display("FAIL rm_ptr: got %b want 10", {m0.Gnt, m1.Gnt}); end
    nxt();
    drv(0, 0, 2'b00, 0, 0);
    drv(1, 0, 2'b00, 0, 0);
    repeat (3) nxt();
  endtask
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_clear();
    test_write_read();
    test_back_to_back();
    test_lanes();
    test_out_of_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/isocm_bram_arbiter.md
ISOCM_BRAM_ARBITER -- requirements
Module: isocm_bram_arbiter

Interface
REQ-001 SHALL have parameter C_MEMSIZE, default 'h4000: BRAM size in bytes.
REQ-002 SHALL have parameter C_PORT_DWIDTH, default 64: data width.
REQ-003 SHALL have parameter C_PORT_AWIDTH, default 32: address width.
REQ-004 SHALL have parameter C_NUM_WE, default 2: write enables, one per 32-bit lane.
REQ-005 SHALL have parameter C_INIT_CLEAR, default 1: zero-fill BRAM after reset when 1.
REQ-006 SHALL have port BRAM_Clk, input, 1: the single clock.
REQ-007 SHALL have port BRAM_Rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port Mn_Req, input, 1, n=0,1: requester n access request.
REQ-009 SHALL have port Mn_WEN, input, [0:1]: lane write enables; all zero means read.
REQ-010 SHALL have port Mn_Addr, input, [0:31]: byte address; bits [29:31] ignored.
REQ-011 SHALL have port Mn_WrData, input, [0:63]: write data.
REQ-012 SHALL have port Mn_Gnt, output, 1: request accepted this cycle.
REQ-013 SHALL have port Mn_RdValid, output, 1: Mn_RdData valid.
REQ-014 SHALL have port Mn_RdData, output, [0:63]: read data.
REQ-015 SHALL have port Mn_Err, output, 1: one-cycle pulse for an out-of-range access.
REQ-016 SHALL have port Busy, output, 1: high while the clear sequence runs.
REQ-017 SHALL have port BRAM_EN, output, 1: BRAM port enable.
REQ-018 SHALL have ports BRAM_WEN [0:1], BRAM_Addr [0:31] and BRAM_Dout [0:63], all outputs to the BRAM.
REQ-019 SHALL have port BRAM_Din, input, [0:63]: BRAM read data, valid one cycle after an enabled read.

Function
REQ-020 SHALL implement FSM states CLEAR and RUN.
- After reset, state is CLEAR if C_INIT_CLEAR=1, otherwise RUN.
REQ-021 In CLEAR, the block SHALL:
- write zero to word k in cycle k, for k = 0..C_MEMSIZE/8-1 (BRAM_EN=1, BRAM_WEN=11, BRAM_Addr=k*8);
- hold Busy=1 and grant nothing;
- enter RUN after the last word.
REQ-022 In RUN, Mn_Gnt SHALL be combinational from Mn_Req and the round-robin pointer.
- At most one grant per cycle.
- A requester holds Mn_Req and its command stable until granted.
REQ-023 Round-robin: when both request, grant the requester not granted most recently.
- Pointer resets to favour M0.
- A lone requester is granted every cycle; back-to-back grants are allowed.
REQ-024 A granted command SHALL appear on the BRAM_* outputs registered, one cycle after the grant.
- BRAM_Addr low three bits are forced to 0.
- BRAM_EN=0 in idle cycles, with BRAM_WEN=00.
REQ-025 For a granted read, Mn_RdValid SHALL pulse exactly two cycles after Mn_Gnt, with Mn_RdData=BRAM_Din.
- Reads SHALL complete in grant order.
- Writes produce no response.
REQ-026 If Mn_Addr >= C_MEMSIZE:
- the request is granted normally;
- no BRAM enable is issued;
- Mn_Err pulses two cycles after the grant;
- a read also returns Mn_RdValid=1 with Mn_RdData=0 in that cycle.
REQ-027 Mn_RdData SHALL be 0 whenever Mn_RdValid=0.
REQ-028 A write followed in the next cycle by a read to the same address (either requester) SHALL return the newly written data.

Reset
REQ-029 While BRAM_Rst=1 every output SHALL be 0, except Busy = C_INIT_CLEAR.
REQ-030 Reset mid-operation SHALL:
- discard in-flight reads, with no Mn_RdValid or Mn_Err afterwards;
- restart CLEAR from word 0;
- reset the round-robin pointer.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (CLEAR, RUN), the lane-width constant 32, and the word-size constant 8.
REQ-032 The two-way round-robin arbiter SHALL be a sub-module named isocm_rr_arb2, with req[1:0], gnt[1:0] and an internal pointer.

Verification
REQ-033 Reset with C_INIT_CLEAR=1, C_MEMSIZE='h4000 -> Busy=1 for 2048 cycles; addresses 0..'h3FF8 written with 0; no grants until RUN.
REQ-034 M0 writes 'h0123456789ABCDEF to 'h10 with WEN=11, then M1 reads 'h10 -> M1_RdValid two cycles after M1_Gnt with that data.
REQ-035 M0 and M1 both request continuously for 6 cycles -> grants alternate M0,M1,M0,M1,M0,M1.
REQ-036 M0 writes 'hFFFFFFFF_FFFFFFFF to 0 with WEN=11, then writes 0 with WEN=10, then reads 0 -> data 'h00000000_FFFFFFFF.
REQ-037 M1 reads 'h4000 -> M1_Err and M1_RdValid pulse together two cycles after grant; RdData=0; BRAM_EN stays 0.
REQ-038 BRAM_Rst asserted the cycle after an M0 read grant -> no M0_RdValid; Busy=1 and CLEAR restarts at word 0.
